// File: rtl/avr_cpu_pkg.sv
// Shared AVR core definitions: pointer select/mode encodings and default widths.
package avr_cpu_pkg;

  localparam int unsigned AVR_DATA_W   = 8;
  localparam int unsigned AVR_NUM_REGS = 32;
  localparam int unsigned PTR_SEL_W    = 2;
  localparam int unsigned PTR_MODE_W   = 2;

  typedef enum logic [PTR_SEL_W-1:0] {
    PTR_NONE = 2'd0,
    PTR_X    = 2'd1,
    PTR_Y    = 2'd2,
    PTR_Z    = 2'd3
  } ptr_sel_e;

  typedef enum logic [PTR_MODE_W-1:0] {
    PTR_PLAIN   = 2'd0,
    PTR_POSTINC = 2'd1,
    PTR_PREDEC  = 2'd2,
    PTR_RSVD    = 2'd3
  } ptr_mode_e;

endpackage

// File: rtl/avr_cpu_ptr_unit.sv
// X/Y/Z pointer engine: selects the pair, forms the effective address and the
// +/-1 update value, and raises per-byte write strobes for the register array.
module avr_cpu_ptr_unit
  import avr_cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = AVR_DATA_W,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned PTR_BASE = 26
) (
  input  logic [6*DATA_W-1:0]   ptr_regs,
  input  logic                  ptr_en,
  input  logic [PTR_SEL_W-1:0]  ptr_sel,
  input  logic [PTR_MODE_W-1:0] ptr_mode,
  output logic [2*DATA_W-1:0]   ptr_addr_c,
  output logic [ADDR_W-1:0]     lo_idx_c,
  output logic [ADDR_W-1:0]     hi_idx_c,
  output logic                  lo_we_c,
  output logic                  hi_we_c,
  output logic [DATA_W-1:0]     lo_next_c,
  output logic [DATA_W-1:0]     hi_next_c
);

  localparam int unsigned PW = 2 * DATA_W;

  logic [PTR_SEL_W-1:0] pair_off;
  logic [PW-1:0]        p;
  logic [PW-1:0]        p_inc;
  logic [PW-1:0]        p_dec;
  logic [PW-1:0]        p_next;
  logic                 active;
  logic                 update;

  always_comb begin
    pair_off   = ptr_sel - PTR_SEL_W'(1);
    p          = ptr_regs[0 +: PW];
    ptr_addr_c = '0;
    p_next     = '0;
    update     = 1'b0;

    case (ptr_sel_e'(ptr_sel))
      PTR_Y:   p = ptr_regs[PW +: PW];
      PTR_Z:   p = ptr_regs[2*PW +: PW];
      default: p = ptr_regs[0 +: PW];
    endcase

    p_inc  = p + PW'(1);
    p_dec  = p - PW'(1);
    active = ptr_en && (ptr_sel_e'(ptr_sel) != PTR_NONE);

    // Reserved mode behaves as plain: address only, no update.
    if (active) begin
      case (ptr_mode_e'(ptr_mode))
        PTR_POSTINC: begin
          ptr_addr_c = p;
          p_next     = p_inc;
          update     = 1'b1;
        end
        PTR_PREDEC: begin
          ptr_addr_c = p_dec;
          p_next     = p_dec;
          update     = 1'b1;
        end
        default: ptr_addr_c = p;
      endcase
    end

    lo_idx_c  = ADDR_W'(PTR_BASE) + ADDR_W'({pair_off, 1'b0});
    hi_idx_c  = lo_idx_c | ADDR_W'(1);
    lo_we_c   = update;
    hi_we_c   = update;
    lo_next_c = p_next[DATA_W-1:0];
    hi_next_c = p_next[PW-1:DATA_W];
  end

endmodule

// File: rtl/avr_cpu_regfile.sv
// AVR general-purpose register file with byte/word write and X/Y/Z pointer update.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module avr_cpu_regfile
  import avr_cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = AVR_DATA_W,
  parameter int unsigned NUM_REGS = AVR_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned PTR_BASE = NUM_REGS - 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     r_addr,
  input  logic [ADDR_W-1:0]     d_addr,
  output logic [DATA_W-1:0]     r_out,
  output logic [DATA_W-1:0]     d_out,
  output logic [2*DATA_W-1:0]   w_out,
  input  logic                  d_we,
  input  logic [DATA_W-1:0]     d_in,
  input  logic                  w_we,
  input  logic [2*DATA_W-1:0]   w_in,
  input  logic                  ptr_en,
  input  logic [PTR_SEL_W-1:0]  ptr_sel,
  input  logic [PTR_MODE_W-1:0] ptr_mode,
  output logic [2*DATA_W-1:0]   ptr_addr
);

  localparam int unsigned PW = 2 * DATA_W;

  logic [DATA_W-1:0]   regs    [NUM_REGS];
  logic [DATA_W-1:0]   wr_data [NUM_REGS];
  logic [DATA_W-1:0]   rd_view [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;
  logic [6*DATA_W-1:0] ptr_regs;
  logic [ADDR_W-1:0]   ptr_lo_idx;
  logic [ADDR_W-1:0]   ptr_hi_idx;
  logic                ptr_lo_we;
  logic                ptr_hi_we;
  logic [DATA_W-1:0]   ptr_lo_next;
  logic [DATA_W-1:0]   ptr_hi_next;
  logic [ADDR_W-1:0]   r_lo;
  logic [ADDR_W-1:0]   r_hi;

  always_comb begin
    ptr_regs = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      ptr_regs[k*DATA_W +: DATA_W] = regs[PTR_BASE + k];
    end
  end

  avr_cpu_ptr_unit #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .PTR_BASE (PTR_BASE)
  ) u_ptr (
    .ptr_regs   (ptr_regs),
    .ptr_en     (ptr_en),
    .ptr_sel    (ptr_sel),
    .ptr_mode   (ptr_mode),
    .ptr_addr_c (ptr_addr),
    .lo_idx_c   (ptr_lo_idx),
    .hi_idx_c   (ptr_hi_idx),
    .lo_we_c    (ptr_lo_we),
    .hi_we_c    (ptr_hi_we),
    .lo_next_c  (ptr_lo_next),
    .hi_next_c  (ptr_hi_next)
  );

  // Per-register write select; word beats byte beats pointer on each register.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wr_en[i]   = 1'b0;
      wr_data[i] = '0;
      if (w_we && ((ADDR_W'(i) | ADDR_W'(1)) == (d_addr | ADDR_W'(1)))) begin
        wr_en[i]   = 1'b1;
        wr_data[i] = i[0] ? w_in[PW-1:DATA_W] : w_in[DATA_W-1:0];
      end else if (d_we && (ADDR_W'(i) == d_addr)) begin
        wr_en[i]   = 1'b1;
        wr_data[i] = d_in;
      end else if (ptr_lo_we && (ADDR_W'(i) == ptr_lo_idx)) begin
        wr_en[i]   = 1'b1;
        wr_data[i] = ptr_lo_next;
      end else if (ptr_hi_we && (ADDR_W'(i) == ptr_hi_idx)) begin
        wr_en[i]   = 1'b1;
        wr_data[i] = ptr_hi_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_en[i]) begin
          regs[i] <= wr_data[i];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
`ifdef REGFILE_BYPASS_EN
      rd_view[i] = (wr_en[i] && !rst) ? wr_data[i] : regs[i];
`else
      rd_view[i] = regs[i];
`endif
    end
  end

  // Out-of-range addresses (non power-of-two NUM_REGS) read as zero.
  always_comb begin
    r_lo  = r_addr & ~ADDR_W'(1);
    r_hi  = r_addr | ADDR_W'(1);
    r_out = (32'(r_addr) < NUM_REGS) ? rd_view[r_addr] : '0;
    d_out = (32'(d_addr) < NUM_REGS) ? rd_view[d_addr] : '0;
    w_out = (32'(r_hi) < NUM_REGS) ? {rd_view[r_hi], rd_view[r_lo]} : '0;
  end

endmodule

// File: tb/tb_avr_cpu_regfile.sv
// Scoreboard bench for avr_cpu_regfile: expected register bytes are queued at
// stimulus time and popped/compared once the write is architecturally visible.
module tb_avr_cpu_regfile;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] r_addr, d_addr;
  logic [DW-1:0] r_out, d_out, d_in;
  logic [15:0]   w_out, w_in, ptr_addr;
  logic          d_we, w_we, ptr_en;
  logic [1:0]    ptr_sel, ptr_mode;

  always #5 clk = ~clk;

  avr_cpu_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .r_addr   (r_addr),
    .d_addr   (d_addr),
    .r_out    (r_out),
    .d_out    (d_out),
    .w_out    (w_out),
    .d_we     (d_we),
    .d_in     (d_in),
    .w_we     (w_we),
    .w_in     (w_in),
    .ptr_en   (ptr_en),
    .ptr_sel  (ptr_sel),
    .ptr_mode (ptr_mode),
    .ptr_addr (ptr_addr)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
    string         name;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [DW-1:0] model [NR];
  int            checks = 0;
  int            failures = 0;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    d_we = 1'b0; w_we = 1'b0; ptr_en = 1'b0; ptr_sel = 2'd0; ptr_mode = 2'd0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] v, input string n);
    exp_t x;
    x.addr = a; x.val = v; x.name = n;
    sb.push_back(x);
  endtask

  task automatic write_byte(input logic [AW-1:0] a, input logic [DW-1:0] v);
    d_addr = a; d_in = v; d_we = 1'b1;
    cyc();
    d_we = 1'b0;
    model[a] = v;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [15:0] v);
    d_addr = a; w_in = v; w_we = 1'b1;
    cyc();
    w_we = 1'b0;
    model[{a[AW-1:1], 1'b0}] = v[7:0];
    model[{a[AW-1:1], 1'b1}] = v[15:8];
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc(); cyc();
    r_addr = 5'd0; d_addr = 5'd31; #1;
    checks++;
    if (r_out !== 8'h00 || d_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold: r_out=%02h d_out=%02h want 00", r_out, d_out);
    end
    rst = 1'b0;
    write_byte(5'd0, 8'h5A);
    write_byte(5'd31, 8'h5A);
    push(5'd0, 8'h5A, "pre_reset_r0");
    push(5'd31, 8'h5A, "pre_reset_r31");
    while (sb.size() > 0) begin
      e = sb.pop_front(); r_addr = e.addr; #1; checks++;
      if (r_out !== e.val) begin
        failures++; $display("FAIL %s: r%0d got %02h want %02h", e.name, e.addr, r_out, e.val);
      end
    end
    r_addr = 5'd0; d_addr = 5'd31;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    checks++;
    if (r_out !== 8'h00 || d_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: r_out=%02h d_out=%02h want 00", r_out, d_out);
    end
    @(negedge clk);
    // Writes and a pointer update presented while reset is held must be lost.
    d_addr = 5'd31; d_in = 8'h66; d_we = 1'b1;
    ptr_en = 1'b1; ptr_sel = 2'd1; ptr_mode = 2'd1;
    cyc();
    idle();
    rst = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      model[i] = 8'h00;
      push(AW'(i), 8'h00, "post_reset_zero");
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); r_addr = e.addr; #1; checks++;
      if (r_out !== e.val) begin
        failures++; $display("FAIL %s: r%0d got %02h want %02h", e.name, e.addr, r_out, e.val);
      end
    end
  endtask

  task automatic test_byte_word();
    write_byte(5'd5, 8'hA5);
    d_addr = 5'd5; #1;
    checks++;
    if (d_out !== 8'hA5) begin
      failures++; $display("FAIL byte_write_d_out: got %02h want a5", d_out);
    end
    write_word(5'd25, 16'h1234);
    push(5'd24, 8'h34, "word_lo");
    push(5'd25, 8'h12, "word_hi");
    // Both strobes: word wins, byte data must not land on r9.
    d_addr = 5'd9; d_in = 8'hEE; d_we = 1'b1; w_in = 16'h4321; w_we = 1'b1;
    cyc();
    idle();
    push(5'd8, 8'h21, "word_over_byte_lo");
    push(5'd9, 8'h43, "word_over_byte_hi");
    while (sb.size() > 0) begin
      e = sb.pop_front(); r_addr = e.addr; #1; checks++;
      if (r_out !== e.val) begin
        failures++; $display("FAIL %s: r%0d got %02h want %02h", e.name, e.addr, r_out, e.val);
      end
    end
    r_addr = 5'd24; #1;
    checks++;
    if (w_out !== 16'h1234) begin
      failures++; $display("FAIL w_out_even: got %04h want 1234", w_out);
    end
    r_addr = 5'd25; #1;
    checks++;
    if (w_out !== 16'h1234) begin
      failures++; $display("FAIL w_out_odd: got %04h want 1234", w_out);
    end
  endtask

  task automatic test_postinc_wrap();
    write_word(5'd26, 16'hFFFF);
    ptr_en = 1'b1; ptr_sel = 2'd1; ptr_mode = 2'd1; #1;
    checks++;
    if (ptr_addr !== 16'hFFFF) begin
      failures++; $display("FAIL postinc_addr: got %04h want ffff", ptr_addr);
    end
    cyc();
    idle(); #1;
    checks++;
    if (ptr_addr !== 16'h0000) begin
      failures++; $display("FAIL ptr_disabled: got %04h want 0000", ptr_addr);
    end
    ptr_en = 1'b1; ptr_sel = 2'd0; ptr_mode = 2'd1; #1;
    checks++;
    if (ptr_addr !== 16'h0000) begin
      failures++; $display("FAIL ptr_sel_none: got %04h want 0000", ptr_addr);
    end
    cyc();
    idle();
    push(5'd26, 8'h00, "postinc_wrap_xl");
    push(5'd27, 8'h00, "postinc_wrap_xh");
    while (sb.size() > 0) begin
      e = sb.pop_front(); r_addr = e.addr; #1; checks++;
      if (r_out !== e.val) begin
        failures++; $display("FAIL %s: r%0d got %02h want %02h", e.name, e.addr, r_out, e.val);
      end
    end
  endtask

  task automatic test_predec_plain();
    write_word(5'd30, 16'h0100);
    ptr_en = 1'b1; ptr_sel = 2'd3; ptr_mode = 2'd2; #1;
    checks++;
    if (ptr_addr !== 16'h00FF) begin
      failures++; $display("FAIL predec_addr: got %04h want 00ff", ptr_addr);
    end
    cyc();
    idle();
    push(5'd30, 8'hFF, "predec_zl");
    push(5'd31, 8'h00, "predec_zh");
    write_word(5'd28, 16'hABCD);
    ptr_en = 1'b1; ptr_sel = 2'd2; ptr_mode = 2'd0; #1;
    checks++;
    if (ptr_addr !== 16'hABCD) begin
      failures++; $display("FAIL plain_addr: got %04h want abcd", ptr_addr);
    end
    cyc();
    ptr_mode = 2'd3; #1;
    checks++;
    if (ptr_addr !== 16'hABCD) begin
      failures++; $display("FAIL reserved_addr: got %04h want abcd", ptr_addr);
    end
    cyc();
    idle();
    push(5'd28, 8'hCD, "plain_yl_kept");
    push(5'd29, 8'hAB, "plain_yh_kept");
    while (sb.size() > 0) begin
      e = sb.pop_front(); r_addr = e.addr; #1; checks++;
      if (r_out !== e.val) begin
        failures++; $display("FAIL %s: r%0d got %02h want %02h", e.name, e.addr, r_out, e.val);
      end
    end
  endtask

  task automatic test_collision();
    write_word(5'd26, 16'h00FF);
    d_addr = 5'd26; d_in = 8'h77; d_we = 1'b1;
    ptr_en = 1'b1; ptr_sel = 2'd1; ptr_mode = 2'd1;
    cyc();
    idle();
    push(5'd26, 8'h77, "coll_byte_xl");
    push(5'd27, 8'h01, "coll_ptr_xh");
    write_word(5'd28, 16'h12FF);
    d_addr = 5'd29; d_in = 8'h99; d_we = 1'b1;
    ptr_en = 1'b1; ptr_sel = 2'd2; ptr_mode = 2'd1;
    cyc();
    idle();
    push(5'd28, 8'h00, "coll_ptr_yl");
    push(5'd29, 8'h99, "coll_byte_yh");
    write_word(5'd30, 16'h1000);
    d_addr = 5'd30; w_in = 16'h5555; w_we = 1'b1;
    ptr_en = 1'b1; ptr_sel = 2'd3; ptr_mode = 2'd2;
    cyc();
    idle();
    push(5'd30, 8'h55, "coll_word_zl");
    push(5'd31, 8'h55, "coll_word_zh");
    while (sb.size() > 0) begin
      e = sb.pop_front(); r_addr = e.addr; #1; checks++;
      if (r_out !== e.val) begin
        failures++; $display("FAIL %s: r%0d got %02h want %02h", e.name, e.addr, r_out, e.val);
      end
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_same;
    write_byte(5'd3, 8'h11);
`ifdef REGFILE_BYPASS_EN
    exp_same = 8'h3C;
`else
    exp_same = 8'h11;
`endif
    r_addr = 5'd3; d_addr = 5'd3; d_in = 8'h3C; d_we = 1'b1; #1;
    checks++;
    if (r_out !== exp_same || d_out !== exp_same) begin
      failures++;
      $display("FAIL same_cycle_read: r_out=%02h d_out=%02h want %02h", r_out, d_out, exp_same);
    end
    cyc();
    idle();
    model[3] = 8'h3C;
    push(5'd3, 8'h3C, "next_cycle_read");
    while (sb.size() > 0) begin
      e = sb.pop_front(); r_addr = e.addr; #1; checks++;
      if (r_out !== e.val) begin
        failures++; $display("FAIL %s: r%0d got %02h want %02h", e.name, e.addr, r_out, e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] nm [NR];
    logic [15:0]   p, n, exp_addr;
    int            lo;
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < int'(NR); i++) model[i] = 8'h00;
    for (int it = 0; it < 80; it++) begin
      d_we     = ($urandom_range(0, 2) == 0);
      w_we     = ($urandom_range(0, 4) == 0);
      d_addr   = AW'($urandom_range(0, NR - 1));
      d_in     = DW'($urandom);
      w_in     = 16'($urandom);
      ptr_en   = ($urandom_range(0, 1) == 1);
      ptr_sel  = 2'($urandom_range(0, 3));
      ptr_mode = 2'($urandom_range(0, 3));
      nm = model;
      exp_addr = 16'h0000;
      if (ptr_en && ptr_sel != 2'd0) begin
        lo = 26 + 2 * (int'(ptr_sel) - 1);
        p = {model[lo + 1], model[lo]};
        exp_addr = (ptr_mode == 2'd2) ? p - 16'd1 : p;
        if (ptr_mode == 2'd1 || ptr_mode == 2'd2) begin
          n = (ptr_mode == 2'd1) ? p + 16'd1 : p - 16'd1;
          nm[lo] = n[7:0];
          nm[lo + 1] = n[15:8];
        end
      end
      if (d_we) nm[d_addr] = d_in;
      if (w_we) begin
        nm[{d_addr[AW-1:1], 1'b0}] = w_in[7:0];
        nm[{d_addr[AW-1:1], 1'b1}] = w_in[15:8];
      end
      #1;
      checks++;
      if (ptr_addr !== exp_addr) begin
        failures++; $display("FAIL b2b_ptr_addr it=%0d: got %04h want %04h", it, ptr_addr, exp_addr);
      end
      cyc();
      idle();
      model = nm;
      lo = int'($urandom_range(0, NR - 1));
      push(AW'(lo), model[lo], "b2b_reg");
      while (sb.size() > 0) begin
        e = sb.pop_front(); r_addr = e.addr; #1; checks++;
        if (r_out !== e.val) begin
          failures++; $display("FAIL %s: r%0d got %02h want %02h", e.name, e.addr, r_out, e.val);
        end
      end
    end
    for (int i = 0; i < int'(NR); i++) push(AW'(i), model[i], "b2b_final");
    while (sb.size() > 0) begin
      e = sb.pop_front(); r_addr = e.addr; #1; checks++;
      if (r_out !== e.val) begin
        failures++; $display("FAIL %s: r%0d got %02h want %02h", e.name, e.addr, r_out, e.val);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    r_addr = '0; d_addr = '0; d_in = '0; w_in = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_byte_word();
    test_postinc_wrap();
    test_predec_plain();
    test_collision();
    test_bypass();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
